pc_sequencer: RTL and testbench

- Owns the fetch PC register of the pipelined RISC-V core and drives the select inputs of the 3-input next-PC mux:
  - sequential PC+4
  - branch/JAL target
  - JALR target `{alu[PC_W-1:1],1'b0}`
- Resolves EX-stage redirects against hazard stalls and a ready/valid instruction-memory handshake.
- Generates the IF/ID and ID/EX flushes.
- Latches a redirect that arrives while instruction memory is busy, so the target is never lost.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_sequencer_redirect_latch.sv | 42 ++++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the fetch PC sequencer.
//   pc_src_e    : select code driven to the 3-input next-PC mux
//   seq_state_e : sequencer state (normal fetch / redirect waiting on imem)
//   PC_INC      : sequential fetch stride in bytes
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,   // PC + 4
        PC_BR   = 2'b01,   // branch / JAL target
        PC_JALR = 2'b10    // JALR target with bit 0 cleared
    } pc_src_e;

    typedef enum logic {
        RUN        = 1'b0,
        WAIT_REDIR = 1'b1
    } seq_state_e;

    localparam int unsigned PC_INC = 4;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_redirect_latch.sv
// -----------------------------------------------------------------------------
// redirect_latch
// Holds a redirect target and its mux select while instruction memory is busy.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : capture i_tgt / i_src this cycle
//   i_tgt, i_src : redirect target and mux select to capture
//   o_tgt, o_src : held target and select
// -----------------------------------------------------------------------------
module redirect_latch
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_tgt,
    input  logic [1:0]      i_src,
    output logic [PC_W-1:0] o_tgt,
    output logic [1:0]      o_src
);

    logic [PC_W-1:0] r_tgt;
    logic [1:0]      r_src;

    // NOTE: state uses non-blocking assignments in an async-reset always_ff so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt <= '0;
            r_src <= PC_SEQ;
        end else if (i_load) begin
            r_tgt <= i_tgt;
            r_src <= i_src;
        end
    end

    assign o_tgt = r_tgt;
    assign o_src = r_src;

endmodule : redirect_latch

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the fetch PC, resolves EX-stage redirects against load-use stalls and
// the instruction-memory ready/valid handshake, drives the next-PC mux select
// and the IF/ID, ID/EX flushes. A redirect that meets a busy imem is parked in
// redirect_latch and replayed on the first ready cycle.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   stall_if            : load-use stall, hold PC
//   imem_ready          : imem accepts the fetch address this cycle
//   ex_valid/branch/taken/jal/jalr : EX-stage control-flow info
//   ex_target           : PC+imm for branch/JAL
//   ex_alu_result       : rs1+imm for JALR
//   pc, imem_req        : fetch address and request
//   pc_src              : next-PC mux select (00 seq, 01 br/jal, 10 jalr)
//   flush_ifid/idex     : pipeline squashes
//   redirect_cnt        : saturating count of accepted redirects
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              DATA_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_if,
    input  logic              imem_ready,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_taken,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic [PC_W-1:0]   ex_target,
    input  logic [DATA_W-1:0] ex_alu_result,
    output logic [PC_W-1:0]   pc,
    output logic              imem_req,
    output logic [1:0]        pc_src,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [CNT_W-1:0]  redirect_cnt
);

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic             r_imem_req;
    logic [CNT_W-1:0] r_cnt;

    logic             w_redir;
    logic             w_adv;
    logic [PC_W-1:0]  w_tgt;
    logic [1:0]       w_src_run;
    logic             w_load;
    logic [PC_W-1:0]  w_pend_tgt;
    logic [1:0]       w_pend_src;
    logic             w_flush_ifid;
    logic             w_flush_idex;
    logic [1:0]       w_pc_src;

    // Only the PC-width slice of the JALR sum matters; bit 0 is always cleared.
    logic w_unused;
    assign w_unused = &{1'b0, ex_alu_result[DATA_W-1:PC_W], ex_alu_result[0]};

    assign w_redir   = ex_valid & (ex_jalr | ex_jal | (ex_branch & ex_taken));
    assign w_tgt     = ex_jalr ? {ex_alu_result[PC_W-1:1], 1'b0} : ex_target;
    assign w_src_run = ex_jalr ? PC_JALR : (w_redir ? PC_BR : PC_SEQ);
    // A redirect overrides the stall: the stalled instruction is wrong-path.
    assign w_adv     = imem_ready & (w_redir | ~stall_if);

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        w_load       = 1'b0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_pc_src     = PC_SEQ;
        case (r_state)
            RUN: begin
                w_pc_src = w_src_run;
                if (w_redir) begin
                    w_flush_ifid = 1'b1;
                    w_flush_idex = 1'b1;
                    if (imem_ready) begin
                        w_pc_next = w_tgt;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = WAIT_REDIR;
                    end
                end else if (w_adv) begin
                    w_pc_next = r_pc + PC_W'(PC_INC);
                end
            end
            WAIT_REDIR: begin
                // EX is empty here (ID/EX was flushed), so EX inputs are ignored.
                w_flush_ifid = 1'b1;
                w_pc_src     = w_pend_src;
                if (imem_ready) begin
                    w_pc_next    = w_pend_tgt;
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    redirect_latch #(.PC_W(PC_W)) u_redirect_latch (
        .clk   (clk),
        .rst_n (reset),
        .i_load(w_load),
        .i_tgt (w_tgt),
        .i_src (w_src_run),
        .o_tgt (w_pend_tgt),
        .o_src (w_pend_src)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_imem_req <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_imem_req <= 1'b1;
            if ((r_state == RUN) && w_redir && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Combinational controls are forced idle while reset is held so reset
    // takes effect on the mux and flushes immediately, not at the next edge.
    assign pc           = r_pc;
    assign imem_req     = r_imem_req;
    assign redirect_cnt = r_cnt;
    assign pc_src       = reset ? w_pc_src : PC_SEQ;
    assign flush_ifid   = reset & w_flush_ifid;
    assign flush_idex   = reset & w_flush_idex;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed steps followed by randomized traffic, each cycle compared against a
// cycle-level reference model of the fetch sequencer.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int PC_W   = 9;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall_if;
    logic              imem_ready;
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_taken;
    logic              ex_jal;
    logic              ex_jalr;
    logic [PC_W-1:0]   ex_target;
    logic [DATA_W-1:0] ex_alu_result;
    logic [PC_W-1:0]   pc;
    logic              imem_req;
    logic [1:0]        pc_src;
    logic              flush_ifid;
    logic              flush_idex;
    logic [CNT_W-1:0]  redirect_cnt;

    pc_sequencer #(
        .PC_W    (PC_W),
        .DATA_W  (DATA_W),
        .RESET_PC('0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_if     (stall_if),
        .imem_ready   (imem_ready),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_taken     (ex_taken),
        .ex_jal       (ex_jal),
        .ex_jalr      (ex_jalr),
        .ex_target    (ex_target),
        .ex_alu_result(ex_alu_result),
        .pc           (pc),
        .imem_req     (imem_req),
        .pc_src       (pc_src),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural view of the sequencer.
    int m_pc;
    bit m_wait;
    int m_pend;
    int m_pend_src;
    int m_cnt;
    int m_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_wait = 0; m_pend = 0; m_pend_src = 0; m_cnt = 0; m_req = 0;
    endtask

    task automatic drive(input bit st, input bit rd, input bit v, input bit br, input bit tk,
                         input bit jl, input bit jr, input int tgt, input logic [31:0] alu);
        stall_if = st; imem_ready = rd; ex_valid = v; ex_branch = br; ex_taken = tk;
        ex_jal = jl; ex_jalr = jr; ex_target = PC_W'(tgt); ex_alu_result = alu;
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // model on the edge, then check registered outputs just after it.
    task automatic step();
        bit          redir;
        int unsigned a;
        int          tgt;
        int          exp_src;
        #2;
        redir = ex_valid && (ex_jalr || ex_jal || (ex_branch && ex_taken));
        a     = ex_alu_result % PC_MOD;
        tgt   = ex_jalr ? int'(a - (a % 2)) : int'(ex_target);
        exp_src = m_wait ? m_pend_src : (ex_jalr ? 2 : (redir ? 1 : 0));
        if (m_wait) check("ex_valid_low_in_wait", 32'(ex_valid), 32'd0);
        check("pc_src", 32'(pc_src), 32'(exp_src));
        check("flush_ifid", 32'(flush_ifid), 32'(m_wait || redir));
        check("flush_idex", 32'(flush_idex), 32'(!m_wait && redir));
        @(posedge clk);
        if (m_wait) begin
            if (imem_ready) begin
                m_pc   = m_pend;
                m_wait = 0;
            end
        end else if (redir) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (imem_ready) m_pc = tgt;
            else begin
                m_pend = tgt; m_pend_src = exp_src; m_wait = 1;
            end
        end else if (imem_ready && !stall_if) begin
            m_pc = (m_pc + 4) % PC_MOD;
        end
        m_req = 1;
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
        check("imem_req", 32'(imem_req), 32'(m_req));
    endtask

    task automatic idle(input bit rd);
        drive(0, rd, 0, 0, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic jal_to(input int tgt);
        drive(0, 1, 1, 0, 0, 1, 0, tgt, 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b0;
        idle(1'b1);
        model_reset();
        #12;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_cnt", 32'(redirect_cnt), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        m_req = 1; m_pc = 4;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_pc", 32'(pc), 32'd4);

        // Taken branch and not-taken branch from 0x10.
        jal_to('h10);
        drive(0, 1, 1, 1, 1, 0, 0, 'h80, 32'd0);
        step();
        check("br_taken_pc", 32'(pc), 32'h80);
        jal_to('h10);
        drive(0, 1, 1, 1, 0, 0, 0, 'h80, 32'd0);
        step();
        check("br_not_taken_pc", 32'(pc), 32'h14);

        // JALR clears bit 0 of the sum.
        drive(0, 1, 1, 0, 0, 0, 1, 'h0, 32'h0000_0133);
        step();
        check("jalr_pc", 32'(pc), 32'h132);

        // Load-use stall holds, redirect overrides stall.
        jal_to('h20);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 32'd0);
            step();
        end
        check("stall_hold_pc", 32'(pc), 32'h20);
        drive(1, 1, 1, 0, 0, 1, 0, 'h100, 32'd0);
        step();
        check("stall_jal_pc", 32'(pc), 32'h100);

        // Redirect while imem busy for 4 cycles, then ready.
        drive(0, 0, 1, 0, 0, 1, 0, 'h60, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            step();
        end
        check("wait_pc_held", 32'(pc), 32'h100);
        idle(1'b1);
        step();
        check("wait_release_pc", 32'(pc), 32'h60);

        // PC wraps modulo 2^PC_W.
        jal_to('h1FC);
        idle(1'b1);
        step();
        check("wrap_pc", 32'(pc), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  m_wait ? 1'b0 : 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, PC_MOD - 1)), $urandom);
            step();
        end
        // Drain any pending redirect before the reset test.
        idle(1'b1);
        step();

        // Reset in the middle of WAIT_REDIR with a latched target.
        drive(0, 0, 1, 0, 0, 1, 0, 'h40, 32'd0);
        step();
        idle(1'b0);
        step();
        check("pre_reset_wait_flush", 32'(flush_ifid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_flush_ifid", 32'(flush_ifid), 32'd0);
        check("mid_rst_flush_idex", 32'(flush_idex), 32'd0);
        check("mid_rst_pc_src", 32'(pc_src), 32'd0);
        check("mid_rst_cnt", 32'(redirect_cnt), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        idle(1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        check("post_rst_pc0", 32'(pc), 32'd0);
        step();
        check("post_rst_pc4", 32'(pc), 32'd4);
        step();
        check("post_rst_pc8", 32'(pc), 32'd8);

        // Counter saturation.
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            jal_to((i % 2) ? 'h30 : 'h50);
        end
        check("cnt_saturated", 32'(redirect_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_pc_sequencer
